dht11_bus_master: RTL
=====================

DHT11_BUS_MASTER -- requirements
Module: dht11_bus_master

Interface
REQ-001 Parameter CLK_PER_US, default 50, meaning sys_clk cycles per microsecond.
REQ-002 Parameter PWR_WAIT_US, default 1_000_000, meaning sensor power-up settle time before the first transaction.
REQ-003 Port sys_clk  in  1  single system clock; all logic rises on this edge.
REQ-004 Port sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port start  in  1  one-cycle request pulse (debounced key); ignored unless ready=1.
REQ-006 Port data_inout  inout  1  open-drain single-wire bus; driven 0 or released to high-Z, never driven 1.
REQ-007 Port ready  out  1  high in IDLE only.
REQ-008 Port hum_int, hum_dec, tem_int, tem_dec  out  8 each  last good frame bytes.
REQ-009 Port data_valid  out  1  one-cycle pulse when new bytes are loaded.
REQ-010 Port err  out  1  one-cycle pulse on checksum failure or timeout.
REQ-011 Port err_code  out  2  held cause of last err: 01 timeout, 10 checksum.

Function
REQ-012 Bus input SHALL pass a 2-flop synchronizer; edge logic SHALL use only the synchronized value.
REQ-013 A free-running 1 us tick SHALL be derived from CLK_PER_US; phase timing SHALL use a microsecond counter cleared on every state change.
REQ-014 States: PWR_WAIT, IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-015 PWR_WAIT -> IDLE after PWR_WAIT_US; start during PWR_WAIT SHALL be dropped.
REQ-016 IDLE -> START_LOW on start; bus driven 0 for 18_000 us.
REQ-017 RELEASE: bus released; -> RESP_LOW on first synced falling edge after >=10 us; timeout at 100 us.
REQ-018 RESP_LOW -> RESP_HIGH on rising edge; RESP_HIGH -> BIT_LOW on falling edge; each timeout 200 us.
REQ-019 BIT_LOW -> BIT_HIGH on rising edge (timeout 100 us); BIT_HIGH measures high width until falling edge (timeout 150 us).
REQ-020 Bit value SHALL be 1 if high width > 40 us, else 0; bits shift MSB-first into a 40-bit register.
REQ-021 After bit 40's falling edge -> CHECK; bus then released and idles high.
REQ-022 CHECK: if (byte0+byte1+byte2+byte3) mod 256 == byte4, load four output bytes and pulse data_valid; else pulse err, err_code=10, outputs unchanged; -> IDLE next cycle.
REQ-023 Any timeout SHALL release bus, pulse err, set err_code=01, discard partial bits, -> IDLE.
REQ-024 start while not in IDLE SHALL be ignored, never queued.
REQ-025 data_valid and err SHALL never assert in the same cycle.

Reset
REQ-026 On sys_rst_n low: state PWR_WAIT, bus released, counters and shift register 0, all byte outputs 0, data_valid=0, err=0, err_code=00, ready=0.
REQ-027 Reset mid-transaction SHALL release the bus immediately (asynchronously) and restart the power-up wait.

Structure
REQ-028 Package dht11_pkg SHALL hold the state enum, phase durations/timeouts (us), bit threshold (40 us) and err_code values.
REQ-029 Sub-module tick_1us (counter, CLK_PER_US-parameterized, one-cycle tick) SHALL be separate; everything else is in one FSM module.

Verification (bench with sensor model, PWR_WAIT_US reduced to 10)
REQ-030 Good frame 0x3A 0x00 0x19 0x05 0x58 -> one data_valid; hum_int=0x3A, hum_dec=0x00, tem_int=0x19, tem_dec=0x05; err never pulses.
REQ-031 Same frame with checksum 0x59 -> err pulse, err_code=10, outputs keep prior values, no data_valid.
REQ-032 Sensor silent after release -> err 100 us after RELEASE entry, err_code=01, ready=1 next cycle.
REQ-033 Bits with 28 us / 70 us high -> decoded 0 / 1; 41 us -> 1, 40 us -> 0.
REQ-034 start pulsed in PWR_WAIT and mid-transaction -> no extra transaction; bus low exactly 18_000 us per accepted start.
REQ-035 Reset asserted during BIT_HIGH -> bus high-Z the same instant; outputs 0; ready only after power-up wait.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire bus master: FSM states,
// phase durations and timeouts in microseconds, and error codes.
package dht11_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        IDLE,
        START_LOW,
        RELEASE,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK
    } state_t;

    // Microsecond counter width; must cover the longest phase (power-up wait)
    localparam int US_W           = 21;
    localparam int FRAME_BITS     = 40;

    localparam int START_LOW_US   = 18_000;
    localparam int RELEASE_MIN_US = 10;
    localparam int RELEASE_TO_US  = 100;
    localparam int RESP_TO_US     = 200;
    localparam int BIT_LOW_TO_US  = 100;
    localparam int BIT_HIGH_TO_US = 150;
    localparam int BIT_THRESH_US  = 40;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;

    function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s == f[7:0];
    endfunction

endpackage

// File: rtl/dht11_bus_master_tick_1us.sv
// Free-running divider producing a one-cycle pulse every CLK_PER_US clocks.
module tick_1us #(
    parameter int CLK_PER_US = 50
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)           r_cnt <= '0;
        else if (r_cnt == LAST) r_cnt <= '0;
        else                    r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/dht11_bus_master.sv
// DHT11 bus master: start pulse, response handshake, 40-bit capture by
// high-pulse width, checksum validation, with per-phase timeouts.
module dht11_bus_master
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US  = 50,
    parameter int PWR_WAIT_US = 1_000_000,
    parameter int START_US    = START_LOW_US
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    inout  wire        data_inout,
    output logic       ready,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] tem_int,
    output logic [7:0] tem_dec,
    output logic       data_valid,
    output logic       err,
    output logic [1:0] err_code
);

    logic                  w_tick;
    logic [1:0]            r_sync;
    logic                  r_bus_d;
    logic                  w_rise;
    logic                  w_fall;
    state_t                r_state;
    logic [US_W-1:0]       r_us;
    logic [US_W-1:0]       w_us_now;
    logic [5:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_bus_low;
    logic                  r_ready;
    logic                  r_valid;
    logic                  r_err;
    logic [1:0]            r_err_code;
    logic [7:0]            r_hum_int, r_hum_dec, r_tem_int, r_tem_dec;
    logic                  w_timeout;

    tick_1us #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .o_tick  (w_tick)
    );

    // Synchronizer resets to the idle-high level so reset exit sees no edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync  <= 2'b11;
            r_bus_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], data_inout};
            r_bus_d <= r_sync[1];
        end
    end

    assign w_rise   = r_sync[1] & ~r_bus_d;
    assign w_fall   = ~r_sync[1] & r_bus_d;
    // Including the current tick makes a W us pulse measure exactly W
    assign w_us_now = r_us + {{(US_W-1){1'b0}}, w_tick};

    always_comb begin
        w_timeout = 1'b0;
        case (r_state)
            RELEASE:   w_timeout = !(w_fall && w_us_now >= US_W'(RELEASE_MIN_US))
                                   && (w_us_now >= US_W'(RELEASE_TO_US));
            RESP_LOW:  w_timeout = !w_rise && (w_us_now >= US_W'(RESP_TO_US));
            RESP_HIGH: w_timeout = !w_fall && (w_us_now >= US_W'(RESP_TO_US));
            BIT_LOW:   w_timeout = !w_rise && (w_us_now >= US_W'(BIT_LOW_TO_US));
            BIT_HIGH:  w_timeout = !w_fall && (w_us_now >= US_W'(BIT_HIGH_TO_US));
            default:   w_timeout = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= PWR_WAIT;
            r_us       <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_bus_low  <= 1'b0;
            r_ready    <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_hum_int  <= '0;
            r_hum_dec  <= '0;
            r_tem_int  <= '0;
            r_tem_dec  <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_us    <= w_us_now;
            if (w_timeout) begin
                r_state    <= IDLE;
                r_ready    <= 1'b1;
                r_err      <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_us       <= '0;
                r_bus_low  <= 1'b0;
            end else begin
                case (r_state)
                    PWR_WAIT: if (w_us_now >= US_W'(PWR_WAIT_US)) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_us    <= '0;
                    end
                    IDLE: begin
                        r_us <= '0;
                        if (start) begin
                            r_state   <= START_LOW;
                            r_ready   <= 1'b0;
                            r_bus_low <= 1'b1;
                        end
                    end
                    START_LOW: if (w_us_now >= US_W'(START_US)) begin
                        r_state   <= RELEASE;
                        r_bus_low <= 1'b0;
                        r_us      <= '0;
                    end
                    RELEASE: if (w_fall && w_us_now >= US_W'(RELEASE_MIN_US)) begin
                        r_state <= RESP_LOW;
                        r_us    <= '0;
                    end
                    RESP_LOW: if (w_rise) begin
                        r_state <= RESP_HIGH;
                        r_us    <= '0;
                    end
                    RESP_HIGH: if (w_fall) begin
                        r_state <= BIT_LOW;
                        r_us    <= '0;
                    end
                    BIT_LOW: if (w_rise) begin
                        r_state <= BIT_HIGH;
                        r_us    <= '0;
                    end
                    BIT_HIGH: if (w_fall) begin
                        r_shift   <= {r_shift[FRAME_BITS-2:0], (w_us_now > US_W'(BIT_THRESH_US))};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_us      <= '0;
                        r_state   <= (r_bit_cnt == 6'(FRAME_BITS - 1)) ? CHECK : BIT_LOW;
                    end
                    CHECK: begin
                        if (checksum_ok(r_shift)) begin
                            r_hum_int <= r_shift[39:32];
                            r_hum_dec <= r_shift[31:24];
                            r_tem_int <= r_shift[23:16];
                            r_tem_dec <= r_shift[15:8];
                            r_valid   <= 1'b1;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_CHECKSUM;
                        end
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                        r_us      <= '0;
                        r_state   <= IDLE;
                        r_ready   <= 1'b1;
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_ready   <= 1'b1;
                        r_bus_low <= 1'b0;
                        r_us      <= '0;
                    end
                endcase
            end
        end
    end

    // Open drain: only ever pull low, otherwise release
    assign data_inout = r_bus_low ? 1'b0 : 1'bz;

    assign ready      = r_ready;
    assign data_valid = r_valid;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign hum_int    = r_hum_int;
    assign hum_dec    = r_hum_dec;
    assign tem_int    = r_tem_int;
    assign tem_dec    = r_tem_dec;

endmodule
